// File: rtl/ram_mem_16b_pkg.sv
// rtl/ram_mem_16b_pkg.sv - shared types for the paired-word RAM
package ram_mem_16b_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } seq_state_e;

endpackage

// File: rtl/ram_sp_sync.sv
// rtl/ram_sp_sync.sv - word array with one synchronous write port and two synchronous read ports
// Read registers clear on reset; the array itself is never reset.
module ram_sp_sync #(
  parameter int DEPTH = 128,
  parameter int WIDTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b
);

  logic [WIDTH-1:0] mem [DEPTH] = '{default: '0};

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Reads sample the array before this edge's write lands, so a collision returns old data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_a <= '0;
      rdata_b <= '0;
    end else if (re) begin
      rdata_a <= mem[raddr_a];
      rdata_b <= mem[raddr_b];
    end
  end

endmodule

// File: rtl/ram_mem_16b.sv
// rtl/ram_mem_16b.sv - complex-pair RAM with random access and a full-array stream sequencer
// Even address holds the real word, odd address the imaginary word of each pair.
module ram_mem_16b
  import ram_mem_16b_pkg::*;
#(
  parameter int MEM_WIDTH  = 128,
  parameter int WORD_WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  input  logic        stream_i,
  output logic [31:0] data_o_a,
  output logic [31:0] data_o_b,
  output logic        valid_o,
  output logic        last_o
);

  localparam int AW = $clog2(MEM_WIDTH);
  localparam int PW = AW - 1;
  localparam logic [PW-1:0] LAST_PAIR = PW'(MEM_WIDTH / 2 - 1);

  seq_state_e state;
  logic [PW-1:0] ptr;

  logic          wr_req;
  logic          rd_req;
  logic          stream_rd;
  logic          mem_re;
  logic [PW-1:0] rd_pair;
  logic [AW-1:0] rd_addr_a;
  logic [AW-1:0] rd_addr_b;

  logic signed [WORD_WIDTH-1:0] word_a;
  logic signed [WORD_WIDTH-1:0] word_b;

  logic unused_bits;
  assign unused_bits = ^{addr_i[31:AW], data_i[31:WORD_WIDTH]};

  // Random access always wins; the stream only reads in cycles where en_i is low.
  assign wr_req    = en_i & we_i;
  assign rd_req    = en_i & ~we_i;
  assign stream_rd = (state == STREAM) & ~en_i;
  assign mem_re    = rd_req | stream_rd;
  assign rd_pair   = en_i ? addr_i[AW-1:1] : ptr;
  assign rd_addr_b = {rd_pair, 1'b0};
  assign rd_addr_a = {rd_pair, 1'b1};

  ram_sp_sync #(
    .DEPTH (MEM_WIDTH),
    .WIDTH (WORD_WIDTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (wr_req),
    .waddr   (addr_i[AW-1:0]),
    .wdata   (data_i[WORD_WIDTH-1:0]),
    .re      (mem_re),
    .raddr_a (rd_addr_a),
    .raddr_b (rd_addr_b),
    .rdata_a (word_a),
    .rdata_b (word_b)
  );

  assign data_o_a = 32'(word_a);
  assign data_o_b = 32'(word_b);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      ptr     <= '0;
      valid_o <= 1'b0;
      last_o  <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      last_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (stream_i && !en_i) begin
            state <= STREAM;
            ptr   <= '0;
          end
        end
        STREAM: begin
          if (!en_i) begin
            valid_o <= 1'b1;
            last_o  <= (ptr == LAST_PAIR);
            // Final pair ends the stream without wrapping the pointer.
            if (ptr == LAST_PAIR) begin
              state <= IDLE;
            end else begin
              ptr <= ptr + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_mem_16b.sv
// tb/tb_ram_mem_16b.sv - scoreboard bench for ram_mem_16b
module tb_ram_mem_16b;

  localparam int PAIRS = 64;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        en_i = 1'b0;
  logic        we_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] data_i = '0;
  logic        stream_i = 1'b0;
  logic [31:0] data_o_a;
  logic [31:0] data_o_b;
  logic        valid_o;
  logic        last_o;

  ram_mem_16b #(
    .MEM_WIDTH  (128),
    .WORD_WIDTH (16)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .en_i     (en_i),
    .we_i     (we_i),
    .addr_i   (addr_i),
    .data_i   (data_i),
    .stream_i (stream_i),
    .data_o_a (data_o_a),
    .data_o_b (data_o_b),
    .valid_o  (valid_o),
    .last_o   (last_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic        valid;
    logic        last;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  function automatic void push(input int due, input logic v, input logic l,
                               input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.due = due; e.valid = v; e.last = l; e.a = a; e.b = b;
    sb.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].due <= cyc) begin
        exp_t e;
        e = sb.pop_front();
        check("due_cycle", cyc, e.due);
        check("valid_o", {31'b0, valid_o}, {31'b0, e.valid});
        check("last_o", {31'b0, last_o}, {31'b0, e.last});
        check("data_o_a", data_o_a, e.a);
        check("data_o_b", data_o_b, e.b);
      end else begin
        check("stray_valid", {31'b0, valid_o}, 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    en_i = 1'b1; we_i = 1'b1; addr_i = addr; data_i = data;
    tick();
    en_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp_a, input logic [31:0] exp_b);
    en_i = 1'b1; we_i = 1'b0; addr_i = addr;
    push(cyc + 1, 1'b0, 1'b0, exp_a, exp_b);
    tick();
    en_i = 1'b0;
  endtask

  task automatic do_stream(input int bubble_p, input int reset_p);
    bit bubbled;
    int p;
    bubbled = 1'b0;
    p = 0;
    stream_i = 1'b1;
    tick();
    stream_i = 1'b0;
    while (p < PAIRS) begin
      if (p == reset_p) begin
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("rst_async_a", data_o_a, 32'd0);
        check("rst_async_b", data_o_b, 32'd0);
        check("rst_async_valid", {31'b0, valid_o}, 32'd0);
        check("rst_async_last", {31'b0, last_o}, 32'd0);
        push(cyc + 1, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        return;
      end
      if (p == bubble_p && !bubbled) begin
        en_i = 1'b1; we_i = 1'b0; addr_i = 32'd0;
        push(cyc + 1, 1'b0, 1'b0, 32'd1, 32'd0);
        tick();
        en_i = 1'b0;
        bubbled = 1'b1;
      end else begin
        push(cyc + 1, 1'b1, (p == PAIRS - 1), 32'(2 * p + 1), 32'(2 * p));
        tick();
        p++;
      end
    end
    tick();
  endtask

  initial begin
    #1 reset_n = 1'b0;
    #1;
    check("reset_a", data_o_a, 32'd0);
    check("reset_b", data_o_b, 32'd0);
    check("reset_valid", {31'b0, valid_o}, 32'd0);
    check("reset_last", {31'b0, last_o}, 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    mon_en = 1'b1;
    tick();

    // Zero memory at start; upper address bits must be ignored on writes.
    rd(32'd5, 32'd0, 32'd0);
    wr(32'hFFFF_FF80, 32'd100);
    wr(32'd1, 32'hFFFF_FFDB);
    rd(32'd0, 32'hFFFF_FFDB, 32'd100);
    push(cyc + 1, 1'b0, 1'b0, 32'hFFFF_FFDB, 32'd100);
    tick();

    wr(32'd2, 32'h0000_7FFF);
    wr(32'd3, 32'h1234_8000);
    rd(32'd3, 32'hFFFF_8000, 32'h0000_7FFF);
    rd(32'd2, 32'hFFFF_8000, 32'h0000_7FFF);

    // stream_i with en_i high is a plain random read and must not start a stream.
    stream_i = 1'b1;
    rd(32'd1, 32'hFFFF_FFDB, 32'd100);
    stream_i = 1'b0;
    repeat (3) tick();

    for (int i = 0; i < 2 * PAIRS; i++) wr(32'(i), 32'(i));
    do_stream(-1, -1);
    do_stream(10, -1);

    rd(32'd4, 32'd5, 32'd4);
    push(cyc + 1, 1'b0, 1'b0, 32'd5, 32'd4);
    wr(32'd4, 32'd7);
    rd(32'd4, 32'd5, 32'd7);
    wr(32'd4, 32'd4);

    do_stream(-1, 20);
    tick();
    do_stream(-1, -1);

    repeat (3) tick();
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
